// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: IDLE/RUN/HALT sequencer feeding a one-entry
// valid/ready output register with a paired next-word lookahead.
module instruction_fetch_unit #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 16,
  parameter logic [2:0]  HALT_OP = 3'b111
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic [DATA_W-1:0] imem_data2,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] instr_next,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              halted,
  output logic [7:0]        retired
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              start_q, start_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] next_q, next_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic              vld_q, vld_d;
  logic [7:0]        ret_q, ret_d;

  logic xfer;
  logic cur_halt;
  logic new_halt;

  assign xfer     = vld_q && instr_ready && !redirect;
  assign cur_halt = vld_q && (instr_q[DATA_W-1 -: 3] == HALT_OP);
  assign new_halt = (imem_data[DATA_W-1 -: 3] == HALT_OP);

  always_comb begin
    state_d = state_q;
    start_d = start;
    pc_d    = pc_q;
    instr_d = instr_q;
    next_d  = next_q;
    ipc_d   = ipc_q;
    vld_d   = vld_q;
    ret_d   = ret_q;
    unique case (1'b1)
      (state_q == RUN): begin
        if (redirect) begin
          vld_d = 1'b0;
          pc_d  = redirect_addr;
        end else begin
          if (xfer && ret_q != 8'hFF)
            ret_d = ret_q + 8'd1;
          if (xfer && cur_halt) begin
            state_d = HALT;
            vld_d   = 1'b0;
          end else if ((!vld_q || xfer) && !cur_halt) begin
            instr_d = imem_data;
            next_d  = imem_data2;
            ipc_d   = pc_q;
            vld_d   = 1'b1;
            // a halt word parks the fetch address on itself
            if (!new_halt)
              pc_d = pc_q + ADDR_W'(1);
          end
        end
      end
      (state_q != RUN): begin
        if (start_q) begin
          state_d = RUN;
          pc_d    = '0;
          ret_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
      next_q  <= '0;
      ipc_q   <= '0;
      vld_q   <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      next_q  <= next_d;
      ipc_q   <= ipc_d;
      vld_q   <= vld_d;
      ret_q   <= ret_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_next  = next_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = vld_q;
  assign halted      = (state_q == HALT);
  assign retired     = ret_q;

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 5: instruction-memory address width, 32 words.
REQ-002 SHALL have parameter DATA_W, default 16: instruction width.
REQ-003 SHALL have parameter HALT_OP, default 3'b111: opcode field instr[15:13] that stops fetching.
REQ-004 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  in  1  level-sampled request to begin fetching from address 0.
REQ-007 SHALL have port imem_addr  out  ADDR_W  fetch address driven to the instruction memory's read address.
REQ-008 SHALL have port imem_data  in  DATA_W  combinational memory word at imem_addr.
REQ-009 SHALL have port imem_data2  in  DATA_W  combinational memory word at imem_addr+1 (mod 32).
REQ-010 SHALL have port instr  out  DATA_W  registered instruction presented downstream.
REQ-011 SHALL have port instr_next  out  DATA_W  registered following word, captured with instr.
REQ-012 SHALL have port instr_pc  out  ADDR_W  address of instr.
REQ-013 SHALL have port instr_valid  out  1  instr/instr_next/instr_pc are valid.
REQ-014 SHALL have port instr_ready  in  1  downstream accepts; transfer when instr_valid && instr_ready.
REQ-015 SHALL have port redirect  in  1  branch/jump request; flushes and reloads fetch address.
REQ-016 SHALL have port redirect_addr  in  ADDR_W  target address for redirect.
REQ-017 SHALL have port halted  out  1  high in HALT state.
REQ-018 SHALL have port retired  out  8  count of transfers since last start; saturates at 255.

Function
REQ-019 SHALL implement states IDLE, RUN, HALT; internal fetch_pc register; imem_addr = fetch_pc combinationally.
REQ-020 SHALL, in IDLE, ignore redirect and instr_ready; start=1 -> RUN with fetch_pc=0, retired=0.
REQ-021 SHALL, in RUN, load output register (instr<=imem_data, instr_next<=imem_data2, instr_pc<=fetch_pc, instr_valid<=1, fetch_pc<=fetch_pc+1) when register empty or transferring this cycle, and no stop condition holds.
REQ-022 SHALL otherwise hold instr, instr_next, instr_pc, instr_valid and fetch_pc unchanged (stall while valid && !ready).
REQ-023 SHALL give latency: start sampled at edge N -> instr_valid high after edge N+2; throughput one instruction per cycle with instr_ready=1.
REQ-024 SHALL wrap fetch_pc from 31 to 0 without flag or stall.
REQ-025 SHALL, on redirect=1 in RUN, at next edge set instr_valid<=0 and fetch_pc<=redirect_addr; redirect overrides load and transfer (no transfer counted that cycle).
REQ-026 SHALL stop loading once the output register holds an instruction with opcode HALT_OP (fetch_pc not advanced past it).
REQ-027 SHALL, on transfer of a HALT_OP instruction, go to HALT with instr_valid<=0; retired counts that transfer.
REQ-028 SHALL, in HALT, assert halted=1, ignore redirect; start=1 -> RUN as in REQ-020.
REQ-029 SHALL increment retired on each transfer, saturating at 255.
REQ-030 SHALL treat start in RUN as no effect.

Reset
REQ-031 SHALL on reset=1, immediately and without clock, force IDLE, fetch_pc=0, instr=0, instr_next=0, instr_pc=0, instr_valid=0, halted=0, retired=0.
REQ-032 SHALL, after reset deasserts mid-operation, remain IDLE until start; no transfer resumes.

Verification
REQ-033 SHALL cover: memory word k = {3'b001,13'(k)}, start pulse, ready=1 -> valid 2 edges after start, instr_pc 0,1,2,... each cycle, retired increments per cycle.
REQ-034 SHALL cover: ready=0 for 3 cycles with instr_pc=4 -> instr, instr_next, instr_pc, fetch_pc stable; retired unchanged; resumes with instr_pc=5.
REQ-035 SHALL cover: redirect to 20 while instr_pc=7 valid -> next cycle valid=0, following cycle instr_pc=20, retired unchanged by redirect cycle.
REQ-036 SHALL cover: word 9 opcode 111 -> after its transfer halted=1, valid=0, retired=10, imem_addr frozen at 9; start then restarts at 0.
REQ-037 SHALL cover: redirect to 30 -> instr_pc 30, 31, 0; at instr_pc=31 instr_next equals word 0.
REQ-038 SHALL cover: reset asserted between edges in RUN -> all outputs zero before next edge; no activity until start.
